// File: rtl/ring_noc_pkg.sv
// Shared types and constants for the 3-port ring router.
// Port count, port-index type and output FSM states.
package ring_noc_pkg;

  localparam int NPORTS = 3;
  localparam int PW     = 2;

  typedef logic [PW-1:0] port_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } ostate_e;

  // Next port around the ring; wraps by compare, not by overflow.
  function automatic port_t port_inc(port_t p);
    if (p == port_t'(NPORTS - 1)) return '0;
    return p + port_t'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among requesters, starting at ptr.
// Purely combinational; one-hot grant plus encoded index.
module rr_arbiter
  import ring_noc_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  port_t             ptr,
  output logic [NPORTS-1:0] gnt,
  output port_t             idx
);

  port_t cand;
  logic  found;

  // Walk the ring from ptr and take the first requester seen.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    if ({1'b0, ptr} < (PW+1)'(NPORTS)) cand = ptr;
    else cand = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        found     = 1'b1;
      end
      cand = port_inc(cand);
    end
  end

endmodule

// File: rtl/ring_switch_allocator.sv
// Wormhole switch allocator: per-output round-robin
// arbitration, then lock to the winner until its tail.
module ring_switch_allocator
  import ring_noc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS-1:0]    in_valid,
  input  logic [NPORTS*PW-1:0] in_dest,
  input  logic [NPORTS-1:0]    in_tail,
  input  logic [NPORTS-1:0]    out_ready,
  output logic [NPORTS-1:0]    in_pop,
  output logic [NPORTS*PW-1:0] xbar_sel,
  output logic [NPORTS-1:0]    out_valid,
  output logic                 err_bad_dest
);

  ostate_e           state_q [NPORTS];
  ostate_e           state_d [NPORTS];
  port_t             owner_q [NPORTS];
  port_t             owner_d [NPORTS];
  port_t             ptr_q   [NPORTS];
  port_t             ptr_d   [NPORTS];
  logic [NPORTS-1:0] inlock_q, inlock_d;
  logic              err_q, err_d;

  logic [NPORTS-1:0] req [NPORTS];
  logic [NPORTS-1:0] gnt [NPORTS];
  port_t             win [NPORTS];
  logic [NPORTS-1:0] bad;
  port_t             dest;

  // Split unlocked heads by destination; catch out-of-range ones.
  always_comb begin
    bad  = '0;
    dest = '0;
    for (int o = 0; o < NPORTS; o++) req[o] = '0;
    for (int i = 0; i < NPORTS; i++) begin
      dest = in_dest[i*PW +: PW];
      if (in_valid[i] && !inlock_q[i]) begin
        if ({1'b0, dest} >= (PW+1)'(NPORTS)) bad[i] = 1'b1;
        for (int o = 0; o < NPORTS; o++)
          if (dest == port_t'(o)) req[o][i] = 1'b1;
      end
    end
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_arb
    rr_arbiter u_arb (
      .req (req[o]),
      .ptr (ptr_q[o]),
      .gnt (gnt[o]),
      .idx (win[o])
    );
  end

  // Locked outputs steer the crossbar and pop their owner.
  always_comb begin
    in_pop    = '0;
    out_valid = '0;
    xbar_sel  = '0;
    for (int o = 0; o < NPORTS; o++) begin
      xbar_sel[o*PW +: PW] = owner_q[o];
      if (state_q[o] == LOCKED) begin
        out_valid[o] = in_valid[owner_q[o]] & out_ready[o];
        in_pop[owner_q[o]] = in_pop[owner_q[o]] | out_valid[o];
      end
    end
  end

  // Output FSMs: claim a winner in IDLE, release on tail pop.
  always_comb begin
    inlock_d = inlock_q;
    err_d    = err_q | (|bad);
    for (int o = 0; o < NPORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      unique case (state_q[o])
        IDLE: begin
          if (|req[o]) begin
            state_d[o] = LOCKED;
            owner_d[o] = win[o];
            inlock_d   = inlock_d | gnt[o];
          end
        end
        LOCKED: begin
          if (out_valid[o] && in_tail[owner_q[o]]) begin
            state_d[o]          = IDLE;
            inlock_d[owner_q[o]] = 1'b0;
            ptr_d[o]            = port_inc(owner_q[o]);
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
      inlock_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
      inlock_q <= inlock_d;
      err_q    <= err_d;
    end
  end

  assign err_bad_dest = err_q;

endmodule

// File: tb/tb_ring_switch_allocator.sv
// Bench for ring_switch_allocator: directed scenarios plus
// random traffic against a packet-level reference model.
module tb_ring_switch_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_valid, in_tail, out_ready;
  logic [5:0] in_dest;
  logic [2:0] in_pop, out_valid;
  logic [5:0] xbar_sel;
  logic       err_bad_dest;

  int checks = 0;
  int passed = 0;

  int m_owner [3];
  int m_ptr   [3];
  int m_sel   [3];
  bit m_lock  [3];
  bit m_err;

  ring_switch_allocator dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_dest      (in_dest),
    .in_tail      (in_tail),
    .out_ready    (out_ready),
    .in_pop       (in_pop),
    .xbar_sel     (xbar_sel),
    .out_valid    (out_valid),
    .err_bad_dest (err_bad_dest)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic void m_reset();
    for (int o = 0; o < 3; o++) begin
      m_owner[o] = -1;
      m_ptr[o]   = 0;
      m_sel[o]   = 0;
      m_lock[o]  = 0;
    end
    m_err = 0;
  endfunction

  function automatic void m_outputs(output logic [2:0] p,
                                    output logic [2:0] v,
                                    output logic [5:0] s);
    p = '0; v = '0; s = '0;
    for (int o = 0; o < 3; o++) begin
      s[o*2 +: 2] = 2'(m_sel[o]);
      if (m_owner[o] >= 0) begin
        v[o] = in_valid[m_owner[o]] & out_ready[o];
        if (v[o]) p[m_owner[o]] = 1'b1;
      end
    end
  endfunction

  function automatic void m_step();
    logic [2:0] p, v;
    logic [5:0] s;
    int nown [3];
    int nptr [3];
    bit nlock [3];
    int w, i;
    bit found;
    m_outputs(p, v, s);
    nown = m_owner; nptr = m_ptr; nlock = m_lock;
    for (int k = 0; k < 3; k++)
      if (in_valid[k] && !m_lock[k] && int'(in_dest[k*2 +: 2]) >= 3)
        m_err = 1;
    for (int o = 0; o < 3; o++) begin
      if (m_owner[o] >= 0) begin
        w = m_owner[o];
        if (v[o] && in_tail[w]) begin
          nown[o] = -1; nlock[w] = 0; nptr[o] = (w + 1) % 3;
        end
      end else begin
        found = 0;
        for (int k = 0; k < 3; k++) begin
          i = (m_ptr[o] + k) % 3;
          if (!found && in_valid[i] && !m_lock[i]
              && int'(in_dest[i*2 +: 2]) == o) begin
            found = 1; nown[o] = i; nlock[i] = 1; m_sel[o] = i;
          end
        end
      end
    end
    m_owner = nown; m_ptr = nptr; m_lock = nlock;
  endfunction

  function automatic void set_dest(int i, int d);
    in_dest[i*2 +: 2] = 2'(d);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = '0; in_dest = '0; in_tail = '0; out_ready = 3'b111;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic adv();
    m_step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 3'b111; in_dest = 6'b00_10_01;
    in_tail = '0; out_ready = 3'b111;
    #1;
    checks++;
    if (in_pop !== 3'b000) $display("FAIL reset_pop: got %b want 000", in_pop);
    else passed++;
    checks++;
    if (out_valid !== 3'b000) $display("FAIL reset_valid: got %b want 000", out_valid);
    else passed++;
    checks++;
    if (xbar_sel !== 6'd0) $display("FAIL reset_sel: got %b want 0", xbar_sel);
    else passed++;
    checks++;
    if (err_bad_dest !== 1'b0) $display("FAIL reset_err: got %b want 0", err_bad_dest);
    else passed++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 3'b000) $display("FAIL reset_hold: got %b want 000", out_valid);
    else passed++;
    rst = 1'b0;
    m_reset();
    #1;
    adv();
    #1;
    checks++;
    if (in_pop !== 3'b111) $display("FAIL reset_release_pop: got %b want 111", in_pop);
    else passed++;
  endtask

  task automatic test_single_flit();
    do_reset();
    in_valid = 3'b010; set_dest(1, 2); in_tail = 3'b010;
    #1;
    checks++;
    if (out_valid !== 3'b000 || in_pop !== 3'b000)
      $display("FAIL single_arb: got v=%b p=%b want 000/000", out_valid, in_pop);
    else passed++;
    adv();
    #1;
    checks++;
    if (out_valid !== 3'b100) $display("FAIL single_valid: got %b want 100", out_valid);
    else passed++;
    checks++;
    if (in_pop !== 3'b010) $display("FAIL single_pop: got %b want 010", in_pop);
    else passed++;
    checks++;
    if (xbar_sel[5:4] !== 2'd1) $display("FAIL single_sel: got %0d want 1", xbar_sel[5:4]);
    else passed++;
    adv();
    in_valid = 3'b110; set_dest(1, 2); set_dest(2, 2); in_tail = 3'b110;
    #1;
    checks++;
    if (out_valid !== 3'b000 || xbar_sel[5:4] !== 2'd1)
      $display("FAIL single_idle: got v=%b sel=%0d want 000/1", out_valid, xbar_sel[5:4]);
    else passed++;
    adv();
    #1;
    checks++;
    if (in_pop !== 3'b100 || xbar_sel[5:4] !== 2'd2)
      $display("FAIL single_ptr: got p=%b sel=%0d want 100/2", in_pop, xbar_sel[5:4]);
    else passed++;
    adv();
    in_valid = '0;
  endtask

  task automatic test_contention();
    logic [2:0] exp_pop [10] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd2,
                                 3'd2, 3'd0, 3'd4, 3'd4, 3'd0};
    int sent [3] = '{0, 0, 0};
    do_reset();
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 3; i++) begin
        in_valid[i] = (sent[i] < 2);
        in_tail[i]  = (sent[i] == 1);
        set_dest(i, 0);
      end
      #1;
      checks++;
      if (in_pop !== exp_pop[c])
        $display("FAIL contention_pop c%0d: got %b want %b", c, in_pop, exp_pop[c]);
      else passed++;
      checks++;
      if (out_valid[0] !== (exp_pop[c] != 3'd0))
        $display("FAIL contention_valid c%0d: got %b", c, out_valid[0]);
      else passed++;
      for (int i = 0; i < 3; i++) if (in_pop[i]) sent[i]++;
      adv();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sent[i] != 2) $display("FAIL contention_count in%0d: got %0d want 2", i, sent[i]);
      else passed++;
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [2:0] exp_pop [10] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0,
                                 3'd1, 3'd1, 3'd0, 3'd4, 3'd0};
    int s0 = 0;
    int s2 = 0;
    do_reset();
    set_dest(0, 1); set_dest(2, 1);
    for (int c = 0; c < 10; c++) begin
      in_valid = {s2 < 1, 1'b0, s0 < 3};
      in_tail  = {1'b1, 1'b0, s0 == 2};
      out_ready = (c >= 2 && c <= 4) ? 3'b101 : 3'b111;
      #1;
      checks++;
      if (in_pop !== exp_pop[c])
        $display("FAIL backpressure_pop c%0d: got %b want %b", c, in_pop, exp_pop[c]);
      else passed++;
      checks++;
      if (out_valid[1] !== (exp_pop[c] != 3'd0))
        $display("FAIL backpressure_valid c%0d: got %b", c, out_valid[1]);
      else passed++;
      if (c == 8) begin
        checks++;
        if (xbar_sel[3:2] !== 2'd2)
          $display("FAIL backpressure_sel: got %0d want 2", xbar_sel[3:2]);
        else passed++;
      end
      if (in_pop[0]) s0++;
      if (in_pop[2]) s2++;
      adv();
    end
    in_valid = '0;
  endtask

  task automatic test_parallel();
    int sent [3] = '{0, 0, 0};
    logic [2:0] want;
    do_reset();
    set_dest(0, 1); set_dest(1, 2); set_dest(2, 0);
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 3; i++) begin
        in_valid[i] = (sent[i] < 4);
        in_tail[i]  = (sent[i] == 3);
      end
      #1;
      want = (c >= 1 && c <= 4) ? 3'b111 : 3'b000;
      checks++;
      if (in_pop !== want || out_valid !== want)
        $display("FAIL parallel c%0d: got p=%b v=%b want %b", c, in_pop, out_valid, want);
      else passed++;
      if (c >= 1 && c <= 4) begin
        checks++;
        if (xbar_sel !== 6'b01_00_10)
          $display("FAIL parallel_sel c%0d: got %b want 010010", c, xbar_sel);
        else passed++;
      end
      for (int i = 0; i < 3; i++) if (in_pop[i]) sent[i]++;
      adv();
    end
    in_valid = '0;
  endtask

  task automatic test_bad_dest();
    logic [2:0] exp_pop [6] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
    int s0 = 0;
    do_reset();
    set_dest(0, 1); set_dest(2, 3);
    for (int c = 0; c < 6; c++) begin
      in_valid = {c < 4, 1'b0, s0 < 2};
      in_tail  = {1'b1, 1'b0, s0 == 1};
      #1;
      checks++;
      if (err_bad_dest !== (c >= 1))
        $display("FAIL bad_dest_err c%0d: got %b want %b", c, err_bad_dest, c >= 1);
      else passed++;
      checks++;
      if (in_pop !== exp_pop[c])
        $display("FAIL bad_dest_pop c%0d: got %b want %b", c, in_pop, exp_pop[c]);
      else passed++;
      if (in_pop[0]) s0++;
      adv();
    end
    in_valid = '0;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_dest(0, 2); set_dest(2, 3);
    in_valid = 3'b101; in_tail = 3'b001;
    #1;
    adv();
    #1;
    checks++;
    if (in_pop !== 3'b001) $display("FAIL midrst_first: got %b want 001", in_pop);
    else passed++;
    adv();
    in_valid = 3'b110; set_dest(1, 2); in_tail = 3'b000;
    #1;
    adv();
    #1;
    checks++;
    if (in_pop !== 3'b010) $display("FAIL midrst_flit1: got %b want 010", in_pop);
    else passed++;
    adv();
    #1;
    checks++;
    if (in_pop !== 3'b010 || err_bad_dest !== 1'b1)
      $display("FAIL midrst_flit2: got p=%b e=%b want 010/1", in_pop, err_bad_dest);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if (in_pop !== 3'b000 || out_valid !== 3'b000)
      $display("FAIL midrst_async: got p=%b v=%b want 000/000", in_pop, out_valid);
    else passed++;
    checks++;
    if (xbar_sel !== 6'd0 || err_bad_dest !== 1'b0)
      $display("FAIL midrst_clear: got sel=%b e=%b want 0/0", xbar_sel, err_bad_dest);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    in_valid = 3'b011; set_dest(0, 2); set_dest(1, 2); in_tail = 3'b011;
    #1;
    checks++;
    if (in_pop !== 3'b000) $display("FAIL midrst_rearb: got %b want 000", in_pop);
    else passed++;
    adv();
    #1;
    checks++;
    if (in_pop !== 3'b001 || xbar_sel[5:4] !== 2'd0)
      $display("FAIL midrst_ptr: got p=%b sel=%0d want 001/0", in_pop, xbar_sel[5:4]);
    else passed++;
    adv();
    in_valid = '0;
  endtask

  task automatic test_random();
    logic [2:0] ep, ev;
    logic [5:0] es;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      in_valid  = 3'($urandom);
      in_tail   = 3'($urandom);
      out_ready = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        if (c > 400 && $urandom_range(0, 31) == 0) set_dest(i, 3);
        else set_dest(i, int'($urandom_range(0, 2)));
      end
      #1;
      m_outputs(ep, ev, es);
      checks++;
      if (in_pop !== ep) $display("FAIL rand_pop c%0d: got %b want %b", c, in_pop, ep);
      else passed++;
      checks++;
      if (out_valid !== ev) $display("FAIL rand_valid c%0d: got %b want %b", c, out_valid, ev);
      else passed++;
      checks++;
      if (xbar_sel !== es) $display("FAIL rand_sel c%0d: got %b want %b", c, xbar_sel, es);
      else passed++;
      checks++;
      if (err_bad_dest !== m_err)
        $display("FAIL rand_err c%0d: got %b want %b", c, err_bad_dest, m_err);
      else passed++;
      adv();
    end
    in_valid = '0;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = '0; in_dest = '0; in_tail = '0; out_ready = '0;
    m_reset();
    #2;
    test_reset();
    test_single_flit();
    test_contention();
    test_backpressure();
    test_parallel();
    test_bad_dest();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ring_switch_allocator.md
Name: ring_switch_allocator

Overview:
- Packet-level switch allocator for the 3-port ring router.
- Sits between the per-input FIFOs/route-compute stage and the crossbar.
- Per output port: round-robin selection among the inputs whose head flit targets that port, then locks the output to the winner until its tail flit passes (wormhole).
- Drives the FIFO read enables, the crossbar selects and the per-output valid.

Parameters:
- NPORTS, 3, number of router ports; each port is both an input and an output.
- PW, 2, width of a port index; must satisfy 2**PW >= NPORTS.

Ports:
- clk  in  1  router clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  NPORTS  input FIFO i is non-empty; its head flit is presented.
- in_dest  in  NPORTS*PW  requested output port for input i's head flit; slice [i*PW +: PW].
- in_tail  in  NPORTS  input i's current flit is the packet's last flit. A single-flit packet has in_tail=1 on its only flit.
- out_ready  in  NPORTS  downstream of output o can accept a flit this cycle.
- in_pop  out  NPORTS  read enable to input FIFO i; flit consumed this cycle.
- xbar_sel  out  NPORTS*PW  per output o, index of the source input driving it.
- out_valid  out  NPORTS  output o carries a valid flit this cycle.
- err_bad_dest  out  1  sticky flag: an in_dest >= NPORTS was seen on a valid, unlocked input.

Behaviour:
- Per-output FSM with states IDLE and LOCKED, plus registers owner[o] (PW bits) and ptr[o] (PW bits).
- Per-input lock bit inlock[i]: set while input i owns any output.

IDLE, output o:
- Requesters: input i with in_valid[i] & ~inlock[i] & in_dest[i]==o.
- Winner: the first requester found searching from ptr[o] upward, mod NPORTS.
- If any requester exists: at the next edge, state goes to LOCKED, owner[o] takes the winner, and inlock[winner] is set.
- No flit is transferred in the arbitration cycle. Arbitration latency is 1 cycle; the first flit can move in the following cycle.
- Same-edge arbitration by two outputs cannot claim one input, because each input presents a single in_dest.

LOCKED, output o:
- out_valid[o] = in_valid[owner] & out_ready[o], combinational from registered state.
- in_pop[owner] = out_valid[o].
- xbar_sel[o] = owner[o].
- in_dest is ignored while locked; body flits carry no routing.
- On a cycle with in_pop[owner] & in_tail[owner]: at the next edge, state goes to IDLE, inlock[owner] clears, and ptr[o] becomes (owner+1) mod NPORTS.
- If in_valid drops mid-packet (FIFO empty) or out_ready=0: stall with the lock held; no pop and no valid.

Outputs and arithmetic:
- In IDLE: out_valid[o]=0 and xbar_sel[o]=owner[o] (last value held).
- in_pop[i] is the OR over outputs; at most one term can be active per input.
- Pointer wrap: NPORTS-1 + 1 → 0. Use explicit compare; do not rely on PW-bit overflow.

Boundary conditions:
- Tail pop and a new request for the same output in the same cycle: the output returns to IDLE and re-arbitrates next cycle. This gives a mandatory 1-cycle bubble between packets.
- An input with in_dest >= NPORTS:
  - never becomes a requester;
  - sets err_bad_dest (cleared only by rst);
  - stalls its input, and other inputs are unaffected.
- All outputs may be LOCKED concurrently, to distinct owners.

Reset (asynchronous, any time including mid-packet):
- All FSMs go to IDLE; owner, ptr and inlock clear to 0.
- in_pop, out_valid, xbar_sel and err_bad_dest all read 0 while rst is high.
- The partial packet is abandoned; FIFO flush is the FIFO's own reset.

Decomposition:
- Shared package ring_noc_pkg holds:
  - NPORTS and PW constants;
  - the output FSM state encoding (IDLE=0, LOCKED=1);
  - the port-index type.
- One sub-module, rr_arbiter:
  - inputs: NPORTS request vector and ptr;
  - outputs: one-hot grant and encoded index, purely combinational;
  - instantiated once per output, NPORTS times.

Test Plan:
- Single-flit packet: input 1 sends in_dest=2, in_tail=1, out_ready=1.
  - Cycle 1: arbitration, all outputs 0.
  - Cycle 2: out_valid[2]=1, xbar_sel[2]=1, in_pop[1]=1.
  - Cycle 3: output 2 back in IDLE with ptr[2]=2.
- Contention: inputs 0, 1 and 2 all target output 0 with 2-flit packets, held continuously from reset.
  - Grant order 0, 1, 2.
  - Each packet pops exactly 2 flits.
  - One idle cycle between packets.
  - No flit from another input is interleaved.
- Backpressure: 3-flit packet 0→1 with out_ready[1] low during flit 2 for 3 cycles.
  - out_valid[1] and in_pop[0] stay 0 for those 3 cycles.
  - The lock is held, and input 2 requesting output 1 is not granted until after the tail.
- Parallel flows: 0→1, 1→2, 2→0 simultaneously.
  - All three outputs locked together.
  - Each output delivers 1 flit/cycle, and in_pop=3'b111 every cycle.
- Bad destination: in_dest=3 on input 2.
  - err_bad_dest=1 next cycle and stays 1.
  - in_pop[2]=0 throughout.
  - Input 0→1 traffic proceeds normally.
- Reset mid-packet: assert rst during flit 2 of a 4-flit packet.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release, a new head on any input is arbitrated from ptr=0.
